// File: rtl/synthesijer_fmul64_issue.sv
// Issue/capture sequencer for the synthesijer_fmul64 core: one multiply in flight at a time.
// Optional WAIT watchdog is compiled in with `define SYNTHESIJER_FMUL64_TIMEOUT_EN.
module synthesijer_fmul64_issue #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [63:0] a_in,
    input  logic [63:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] result_out,
    output logic        err,
    output logic [63:0] core_a,
    output logic [63:0] core_b,
    output logic        core_nd,
    input  logic [63:0] core_result,
    input  logic        core_valid
);

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] QNAN = 64'h7FF8_0000_0000_0000;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("synthesijer_fmul64_issue: TIMEOUT out of range 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            nd_q, nd_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   res_q, res_d;

`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nd_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nd_q    <= nd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_ISSUE;
                    a_d     = a_in;
                    b_d     = b_in;
`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // A real result always beats a coincident timeout
                if (core_valid) begin
                    state_d = S_DONE;
                    res_d   = core_result;
                end
`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    res_d   = QNAN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        nd_d   = (state_d == S_ISSUE);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign core_nd    = nd_q;
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign result_out = res_q;

`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_synthesijer_fmul64_issue.sv
// Directed-plus-random bench for synthesijer_fmul64_issue with an inline latency-L core model.
module tb_synthesijer_fmul64_issue;

    localparam int unsigned TO = 16;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [63:0] a_in, b_in;
    logic        busy, done, err, core_nd, core_valid;
    logic [63:0] result_out, core_a, core_b, core_result;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_res, exp_a, exp_b;
    logic        exp_err;

    synthesijer_fmul64_issue #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .result_out  (result_out),
        .err         (err),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_nd     (core_nd),
        .core_result (core_result),
        .core_valid  (core_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_held(input string tag);
        chk({tag, ".result"}, result_out, exp_res);
        chk({tag, ".core_a"}, core_a, exp_a);
        chk({tag, ".core_b"}, core_b, exp_b);
        chk({tag, ".err"}, 64'(err), 64'(exp_err));
    endtask

    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    // One transaction: req in cycle 0, nd in cycle 1, valid in cycle 1+lat, done in 2+lat.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int lat,
                          input bit hold, input bit poke4, input bit no_valid);
        logic [63:0] p;
        p    = fmul(a, b);
        req  = 1'b1;
        a_in = a;
        b_in = b;
        step();
        exp_a   = a;
        exp_b   = b;
        exp_err = 1'b0;
        req     = hold;
        for (int c = 1; c <= lat + 1; c++) begin
            if (c > 1) step();
            chk("op.nd", 64'(core_nd), 64'(c == 1));
            chk("op.busy", 64'(busy), 64'd1);
            chk("op.done", 64'(done), 64'd0);
            chk_held("op");
            if (poke4 && c == 4) begin
                req  = 1'b1;
                a_in = 64'h3FF0_0000_0000_0000;
            end else if (poke4 && c == 5) begin
                req  = hold;
            end
            if (c == lat + 1 && !no_valid) begin
                core_valid  = 1'b1;
                core_result = p;
            end
        end
        step();
        core_valid  = 1'b0;
        core_result = {$urandom, $urandom};
        if (no_valid) begin
            exp_res = QNAN;
            exp_err = 1'b1;
        end else begin
            exp_res = p;
        end
        chk("done.pulse", 64'(done), 64'd1);
        chk("done.busy", 64'(busy), 64'd1);
        chk("done.nd", 64'(core_nd), 64'd0);
        chk_held("done");
        step();
        chk("after.done", 64'(done), 64'd0);
        chk("after.busy", 64'(busy), 64'd0);
        chk("after.nd", 64'(core_nd), 64'd0);
        chk_held("after");
    endtask

    initial begin
        reset       = 1'b1;
        req         = 1'b0;
        a_in        = '0;
        b_in        = '0;
        core_valid  = 1'b0;
        core_result = '0;
        exp_res = '0;
        exp_a   = '0;
        exp_b   = '0;
        exp_err = 1'b0;

        // Reset then idle
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle.busy", 64'(busy), 64'd0);
            chk("idle.done", 64'(done), 64'd0);
            chk("idle.nd", 64'(core_nd), 64'd0);
            chk_held("idle");
        end

        // Basic 2.0 * 3.0 with L=8, plus an ignored request in cycle 4
        run_op(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 8, 1'b0, 1'b1, 1'b0);
        chk("basic.six", result_out, 64'h4018_0000_0000_0000);

        // Back-to-back with req held high
        run_op(64'h4010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 8, 1'b1, 1'b0, 1'b0);
        run_op(64'hC000_0000_0000_0000, 64'h4014_0000_0000_0000, 8, 1'b0, 1'b0, 1'b0);

        // Random operands and latencies; result passes through bit-exact
        for (int k = 0; k < 6; k++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(1, 10)), 1'b0, 1'b0, 1'b0);
        end

        // Stray valid in IDLE
        core_valid  = 1'b1;
        core_result = {$urandom, $urandom};
        step();
        chk("stray.done", 64'(done), 64'd0);
        chk_held("stray");
        step();
        core_valid = 1'b0;
        chk("stray.busy", 64'(busy), 64'd0);
        chk_held("stray2");

        // Reset asserted in WAIT
        req  = 1'b1;
        a_in = 64'h4000_0000_0000_0000;
        b_in = 64'h4000_0000_0000_0000;
        step();
        req = 1'b0;
        step();
        step();
        step();
        chk("rst.pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        exp_res = '0;
        exp_a   = '0;
        exp_b   = '0;
        exp_err = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.nd", 64'(core_nd), 64'd0);
        chk_held("rst");
        step();
        reset       = 1'b0;
        core_valid  = 1'b1;
        core_result = 64'h4010_0000_0000_0000;
        step();
        core_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst.done", 64'(done), 64'd0);
            chk("postrst.busy", 64'(busy), 64'd0);
            chk_held("postrst");
        end

`ifdef SYNTHESIJER_FMUL64_TIMEOUT_EN
        // Watchdog: timeout, then clear on next req with valid coinciding with timeout cycle
        run_op(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, TO, 1'b0, 1'b0, 1'b1);
        chk("wd.err", 64'(err), 64'd1);
        run_op(64'h4008_0000_0000_0000, 64'h4008_0000_0000_0000, TO, 1'b0, 1'b0, 1'b0);
        chk("wd.coincide", result_out, 64'h4022_0000_0000_0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synthesijer_fmul64_issue.md
# synthesijer_fmul64_issue

Single-request issue/capture sequencer between a generated method FSM and the `synthesijer_fmul64` double-precision multiplier core. It latches one operand pair per request and drives the core's `nd` strobe for exactly one cycle. It waits for the core's `valid`, then holds the product stable and reports completion with a one-cycle `done` pulse. One multiply is in flight at a time, so the caller never has to track core latency.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before the watchdog fires; legal range 1..65535. Used only when the watchdog is compiled in.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  system clock; all state updates on the rising edge.
  - `reset`  in  1  asynchronous, active-high reset.
- Caller side:
  - `req`  in  1  request strobe; sampled only in IDLE.
  - `a_in`  in  64  IEEE-754 double operand A, sampled with `req`.
  - `b_in`  in  64  IEEE-754 double operand B, sampled with `req`.
  - `busy`  out  1  registered; 1 in ISSUE, WAIT and DONE.
  - `done`  out  1  registered; one-cycle completion pulse.
  - `result_out`  out  64  registered product, held until the next `done`.
  - `err`  out  1  sticky timeout flag.
- Core side:
  - `core_a`  out  64  operand A register, connected to the core's `a`.
  - `core_b`  out  64  operand B register, connected to the core's `b`.
  - `core_nd`  out  1  registered new-data strobe to the core.
  - `core_result`  in  64  core result.
  - `core_valid`  in  1  core result-valid strobe.

## Operation
- State machine: IDLE, ISSUE, WAIT, DONE.
  - IDLE to ISSUE when `req`=1. On that edge, `core_a`←`a_in`, `core_b`←`b_in`, and `err`←0.
  - ISSUE to WAIT unconditionally. `core_nd`=1 only while in ISSUE.
  - WAIT to DONE when `core_valid`=1. On that edge, `result_out`←`core_result`.
  - DONE to IDLE unconditionally. `done`=1 only while in DONE.
- `req` is ignored outside IDLE. There is no queueing; the caller must wait for `done`.
- `core_valid` is ignored outside WAIT. A stray `core_valid` in IDLE, ISSUE or DONE causes no state change and no capture.
- `core_a` and `core_b` hold their values from ISSUE until the next accepted `req`.
- The block does no arithmetic. `core_result` passes through bit-exact, including NaN, Inf and denormal values.
- Reset values: state=IDLE; `busy`=0, `done`=0, `core_nd`=0, `err`=0; `result_out`=0, `core_a`=0, `core_b`=0; watchdog counter=0.
- Reset asserted mid-operation returns the block to IDLE with reset values. Any `core_valid` that arrives after reset is released is ignored.

## Timing
- Take the accepted `req` as cycle 0 and let L be the core latency from `nd` to `valid`.
  - `core_nd` is high in cycle 1.
  - `core_valid` is expected in cycle 1+L.
  - `done` is high and `result_out` is valid in cycle 2+L.
- Throughput is one multiply per L+3 cycles at best: the next `req` is accepted in cycle 3+L, the first IDLE cycle after DONE.
- `req` held high continuously launches a new operation on every IDLE cycle.

## Configuration
- Macro `SYNTHESIJER_FMUL64_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments on each WAIT cycle without `core_valid`.
  - When the count reaches `TIMEOUT`, the block goes WAIT to DONE and sets `err`←1.
  - On that edge, `result_out`←64'h7FF8000000000000 (quiet NaN).
  - If `core_valid` and the timeout coincide in the same cycle, `core_valid` wins: the real result is captured and `err` stays 0.
- Undefined:
  - No counter is built, WAIT persists indefinitely, and `err` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Reset then idle: after reset release, all outputs read 0 and `busy`=0 for 10 cycles with `req`=0.
- Basic multiply with L=8: `req` with `a_in`=0x4000000000000000 (2.0) and `b_in`=0x4008000000000000 (3.0).
  - `core_nd` pulses in cycle 1.
  - `done` pulses in cycle 10 with `result_out`=0x4018000000000000 (6.0).
  - `busy` is high in cycles 1–10.
- Request while busy: a second `req` with `a_in`=0x3FF0000000000000 in cycle 4.
  - It is ignored: no second `core_nd`, and `core_a` stays 0x4000000000000000.
- Back-to-back with `req` held high: two multiplies complete.
  - The second `core_nd` occurs exactly L+3 cycles after the first.
  - `result_out` holds the first product until the second `done`.
- Stray valid and reset mid-op:
  - `core_valid` in IDLE leaves `result_out` unchanged.
  - Reset asserted in WAIT forces IDLE; a `core_valid` after reset release causes no `done`.
- Watchdog (macro defined, `TIMEOUT`=16, core never valid):
  - `done` and `err`=1 with `result_out`=0x7FF8000000000000.
  - The next `req` clears `err`.
  - A `core_valid` coinciding with the timeout cycle yields `err`=0 and the core value in `result_out`.
